// File: rtl/imem_responder.sv
// imem_responder: instruction-memory end of the fetch interface; fixed-latency in-order
// responses through a credit-counted response buffer, with a preload write port.
module imem_responder #(
  parameter int NUM_BITS   = 32,
  parameter int MEM_WORDS  = 256,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic [NUM_BITS-1:0] req_addr,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic [NUM_BITS-1:0] resp_addr,
  output logic [NUM_BITS-1:0] resp_inst,
  output logic                resp_err,
  input  logic                wr_en,
  input  logic [NUM_BITS-1:0] wr_addr,
  input  logic [NUM_BITS-1:0] wr_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);
  localparam logic [NUM_BITS-1:0] NOP = NUM_BITS'(32'h0000_0013);

  logic [NUM_BITS-1:0] mem [MEM_WORDS];
  logic [NUM_BITS-1:0] b_addr [RESP_DEPTH];
  logic [NUM_BITS-1:0] b_inst [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] b_err;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] outs, cnt;
  logic acc, cons, fin_val, fin_err;
  logic [NUM_BITS-1:0] fin_addr;

  // Outstanding count covers pipeline plus buffer, so the buffer can never overflow
  assign req_rdy   = rst_n && (outs < FULL);
  assign acc       = req_val && req_rdy;
  assign resp_val  = cnt != '0;
  assign cons      = resp_val && resp_rdy;
  assign resp_addr = b_addr[rp];
  assign resp_inst = b_inst[rp];
  assign resp_err  = b_err[rp];
  assign fin_err   = (|fin_addr[1:0]) || (|fin_addr[NUM_BITS-1:AW+2]);

  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_val  = acc;
      assign fin_addr = req_addr;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv;
      logic [NUM_BITS-1:0] pa [LATENCY-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv <= '0;
        else begin
          pv[0] <= acc;
          for (int i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
        end
      end
      always_ff @(posedge clk) begin
        pa[0] <= req_addr;
        for (int i = 1; i < LATENCY - 1; i++) pa[i] <= pa[i-1];
      end
      assign fin_val  = pv[LATENCY-2];
      assign fin_addr = pa[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      outs <= '0;
      cnt  <= '0;
    end else begin
      outs <= (acc && !cons) ? outs + 1'b1 : (!acc && cons) ? outs - 1'b1 : outs;
      cnt  <= (fin_val && !cons) ? cnt + 1'b1 : (!fin_val && cons) ? cnt - 1'b1 : cnt;
      if (fin_val) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (cons) rp <= (rp == LAST) ? '0 : rp + 1'b1;
    end
  end

  // Read and write share an edge, so a colliding read captures the pre-write word
  always_ff @(posedge clk) begin
    if (wr_en && !(|wr_addr[NUM_BITS-1:AW+2])) mem[wr_addr[2 +: AW]] <= wr_data;
    if (fin_val) begin
      b_addr[wp] <= fin_addr;
      b_err[wp]  <= fin_err;
      b_inst[wp] <= fin_err ? NOP : mem[fin_addr[2 +: AW]];
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed checks of imem_responder against an
// in-order, fixed-latency transaction model.
module tb_imem_responder;
  localparam int L = 2;
  localparam int D = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_val = 0, resp_rdy = 0, wr_en = 0;
  logic [31:0] req_addr = 0, wr_addr = 0, wr_data = 0;
  logic req_rdy, resp_val, resp_err;
  logic [31:0] resp_addr, resp_inst;

  logic s_req_val = 0, s_resp_rdy = 1, s_wr_en = 0;
  logic [31:0] s_req_addr = 0, s_wr_addr = 0, s_wr_data = 0;
  logic s_req_rdy, s_resp_val, s_resp_err;
  logic [31:0] s_resp_addr, s_resp_inst;
  logic [31:0] smem [16];

  imem_responder #(.NUM_BITS(32), .MEM_WORDS(256), .LATENCY(L), .RESP_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_addr(resp_addr), .resp_inst(resp_inst),
    .resp_err(resp_err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  imem_responder #(.NUM_BITS(32), .MEM_WORDS(256), .LATENCY(2), .RESP_DEPTH(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_val(s_req_val), .req_rdy(s_req_rdy), .req_addr(s_req_addr),
    .resp_val(s_resp_val), .resp_rdy(s_resp_rdy), .resp_addr(s_resp_addr),
    .resp_inst(s_resp_inst), .resp_err(s_resp_err), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data));

  // Model: each accepted request becomes visible L-1 edges after acceptance, in order
  typedef struct {
    logic [31:0] addr;
    int          ready;
    logic [31:0] inst;
    logic        err;
  } ent_t;
  ent_t q[$];
  int outs = 0, cyc = 0, n_chk = 0, n_fail = 0;
  logic [31:0] mem_m [256];

  function automatic bit m_rdy();
    return rst_n && outs < D;
  endfunction
  function automatic bit m_val();
    return q.size() > 0 && cyc >= q[0].ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      outs = 0;
    end else begin
      bit acc, cons;
      cons = m_val() && resp_rdy;
      acc  = req_val && m_rdy();
      cyc++;
      if (cons) void'(q.pop_front());
      if (acc) q.push_back('{req_addr, cyc + L - 1, 32'h0, 1'b0});
      foreach (q[i]) if (q[i].ready == cyc) begin
        q[i].err  = (q[i].addr % 4 != 0) || (q[i].addr >= 1024);
        q[i].inst = q[i].err ? NOP : mem_m[q[i].addr / 4];
      end
      outs += int'(acc) - int'(cons);
      if (wr_en && wr_addr < 1024) mem_m[wr_addr / 4] = wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk += 2;
    if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset req_rdy got %b exp 0", req_rdy); end
    if (resp_val !== 1'b0) begin n_fail++; $display("FAIL reset resp_val got %b exp 0", resp_val); end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release req_rdy got %b exp 1", req_rdy); end
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      wr_addr = i * 4;
      wr_data = (i == 0) ? 32'h0050_0093 : $urandom;
      s_wr_en = i < 16;
      s_wr_addr = i * 4;
      if (i < 16) begin smem[i] = $urandom; s_wr_data = smem[i]; end
      step();
    end
    s_wr_en = 1'b0;
    wr_addr = 32'h400;
    wr_data = 32'hffff_ffff;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_single();
    resp_rdy = 1'b1;
    req_val = 1'b1;
    req_addr = 32'h0;
    for (int s = 0; s < 5; s++) begin
      n_chk += 2;
      if (req_rdy !== m_rdy()) begin n_fail++; $display("FAIL single req_rdy got %b exp %b", req_rdy, m_rdy()); end
      if (resp_val !== m_val()) begin n_fail++; $display("FAIL single resp_val got %b exp %b", resp_val, m_val()); end
      if (m_val()) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {q[0].addr, q[0].inst, q[0].err}) begin
          n_fail++; $display("FAIL single resp got %h/%h/%b exp %h/%h/%b", resp_addr, resp_inst, resp_err, q[0].addr, q[0].inst, q[0].err);
        end
      end
      if (s == 1 || s == 2) begin
        n_chk++;
        if (resp_val !== (s == 2)) begin n_fail++; $display("FAIL single_latency s=%0d resp_val got %b exp %b", s, resp_val, s == 2); end
      end
      if (s == 2) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {32'h0, 32'h0050_0093, 1'b0}) begin
          n_fail++; $display("FAIL single_data got %h/%h/%b exp 0/00500093/0", resp_addr, resp_inst, resp_err);
        end
      end
      step();
      req_val = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] held = 0;
    int k = 0, first_cons = -1, acc8 = -1;
    resp_rdy = 1'b0;
    for (int s = 0; s < 14; s++) begin
      req_val = k < 3;
      if (k < 3) req_addr = addrs[k];
      if (s == 6) resp_rdy = 1'b1;
      n_chk += 2;
      if (req_rdy !== m_rdy()) begin n_fail++; $display("FAIL bp req_rdy s=%0d got %b exp %b", s, req_rdy, m_rdy()); end
      if (resp_val !== m_val()) begin n_fail++; $display("FAIL bp resp_val s=%0d got %b exp %b", s, resp_val, m_val()); end
      if (m_val()) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {q[0].addr, q[0].inst, q[0].err}) begin
          n_fail++; $display("FAIL bp resp got %h/%h/%b exp %h/%h/%b", resp_addr, resp_inst, resp_err, q[0].addr, q[0].inst, q[0].err);
        end
      end
      if (s == 2) held = resp_inst;
      if (s >= 3 && s <= 5) begin
        n_chk++;
        if (req_rdy !== 1'b0 || resp_val !== 1'b1 || resp_addr !== 32'h0 || resp_inst !== held) begin
          n_fail++; $display("FAIL bp_hold s=%0d got rdy=%b val=%b addr=%h inst=%h exp 0/1/0/%h", s, req_rdy, resp_val, resp_addr, resp_inst, held);
        end
      end
      if (resp_val && resp_rdy && first_cons < 0) first_cons = s;
      if (req_val && req_rdy && k == 2) acc8 = s;
      if (req_val && m_rdy()) k++;
      step();
    end
    n_chk += 2;
    if (first_cons != 6) begin n_fail++; $display("FAIL bp_first_consume got %0d exp 6", first_cons); end
    if (acc8 != first_cons + 1) begin n_fail++; $display("FAIL bp_reopen got %0d exp %0d", acc8, first_cons + 1); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4] = '{32'h6, 32'h400, 32'hffff_fffc, 32'h3fc};
    int k = 0, j = 0;
    resp_rdy = 1'b1;
    for (int s = 0; s < 14; s++) begin
      req_val = k < 4;
      if (k < 4) req_addr = addrs[k];
      n_chk += 2;
      if (req_rdy !== m_rdy()) begin n_fail++; $display("FAIL err req_rdy got %b exp %b", req_rdy, m_rdy()); end
      if (resp_val !== m_val()) begin n_fail++; $display("FAIL err resp_val got %b exp %b", resp_val, m_val()); end
      if (m_val()) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {q[0].addr, q[0].inst, q[0].err}) begin
          n_fail++; $display("FAIL err resp got %h/%h/%b exp %h/%h/%b", resp_addr, resp_inst, resp_err, q[0].addr, q[0].inst, q[0].err);
        end
      end
      if (resp_val && resp_rdy && j < 4) begin
        n_chk++;
        if (resp_addr !== addrs[j] || resp_err !== (j < 3) || (j < 3 && resp_inst !== NOP) || (j == 3 && resp_inst !== mem_m[255])) begin
          n_fail++; $display("FAIL err_case%0d got %h/%h/%b exp addr %h err %b", j, resp_addr, resp_inst, resp_err, addrs[j], j < 3);
        end
        j++;
      end
      if (req_val && m_rdy()) k++;
      step();
    end
    n_chk++;
    if (j != 4) begin n_fail++; $display("FAIL err_count got %0d exp 4", j); end
  endtask

  task automatic test_collision();
    logic [31:0] a = $urandom;
    logic [31:0] b = ~a;
    int j = 0;
    wr_en = 1'b1; wr_addr = 32'hc; wr_data = a;
    step();
    wr_en = 1'b0;
    for (int s = 0; s < 8; s++) begin
      req_val = s < 2;
      req_addr = 32'hc;
      wr_en = s == 1;
      wr_data = b;
      n_chk += 2;
      if (req_rdy !== m_rdy()) begin n_fail++; $display("FAIL coll req_rdy got %b exp %b", req_rdy, m_rdy()); end
      if (resp_val !== m_val()) begin n_fail++; $display("FAIL coll resp_val got %b exp %b", resp_val, m_val()); end
      if (m_val()) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {q[0].addr, q[0].inst, q[0].err}) begin
          n_fail++; $display("FAIL coll resp got %h/%h/%b exp %h/%h/%b", resp_addr, resp_inst, resp_err, q[0].addr, q[0].inst, q[0].err);
        end
      end
      if (resp_val && resp_rdy && j < 2) begin
        n_chk++;
        if (resp_inst !== (j == 0 ? a : b)) begin n_fail++; $display("FAIL coll_word%0d got %h exp %h", j, resp_inst, j == 0 ? a : b); end
        j++;
      end
      step();
    end
    wr_en = 1'b0;
    n_chk++;
    if (j != 2) begin n_fail++; $display("FAIL coll_count got %0d exp 2", j); end
  endtask

  task automatic test_reset_midflight();
    int j = 0;
    resp_rdy = 1'b0;
    req_val = 1'b1;
    req_addr = 32'h10; step();
    req_addr = 32'h14; step();
    req_val = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (resp_val !== 1'b0) begin n_fail++; $display("FAIL arst resp_val got %b exp 0", resp_val); end
    if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL arst req_rdy got %b exp 0", req_rdy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL arst_release req_rdy got %b exp 1", req_rdy); end
    resp_rdy = 1'b1;
    for (int s = 0; s < 10; s++) begin
      req_val = s < 2;
      req_addr = (s == 0) ? 32'hffff_fffc : 32'h0;
      n_chk += 2;
      if (req_rdy !== m_rdy()) begin n_fail++; $display("FAIL arst req_rdy got %b exp %b", req_rdy, m_rdy()); end
      if (resp_val !== m_val()) begin n_fail++; $display("FAIL arst resp_val got %b exp %b", resp_val, m_val()); end
      if (m_val()) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {q[0].addr, q[0].inst, q[0].err}) begin
          n_fail++; $display("FAIL arst resp got %h/%h/%b exp %h/%h/%b", resp_addr, resp_inst, resp_err, q[0].addr, q[0].inst, q[0].err);
        end
      end
      if (resp_val && resp_rdy) begin
        n_chk++;
        if (j == 0 ? {resp_addr, resp_inst, resp_err} !== {32'hffff_fffc, NOP, 1'b1}
                   : {resp_addr, resp_inst, resp_err} !== {32'h0, 32'h0050_0093, 1'b0}) begin
          n_fail++; $display("FAIL arst_resp%0d got %h/%h/%b", j, resp_addr, resp_inst, resp_err);
        end
        j++;
      end
      @(posedge clk); @(negedge clk); #1;
    end
    n_chk++;
    if (j != 2) begin n_fail++; $display("FAIL arst_count got %0d exp 2", j); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 320; s++) begin
      bit drain = s >= 300;
      req_val = !drain && ($urandom % 4 != 0);
      req_addr = ($urandom % 6 == 0) ? $urandom : ($urandom % 256) * 4;
      resp_rdy = drain || ($urandom % 3 != 0);
      wr_en = !drain && ($urandom % 5 == 0);
      wr_addr = ($urandom % 8 == 0) ? $urandom : ($urandom % 256) * 4;
      wr_data = $urandom;
      n_chk += 2;
      if (req_rdy !== m_rdy()) begin n_fail++; $display("FAIL rand req_rdy s=%0d got %b exp %b", s, req_rdy, m_rdy()); end
      if (resp_val !== m_val()) begin n_fail++; $display("FAIL rand resp_val s=%0d got %b exp %b", s, resp_val, m_val()); end
      if (m_val()) begin
        n_chk++;
        if ({resp_addr, resp_inst, resp_err} !== {q[0].addr, q[0].inst, q[0].err}) begin
          n_fail++; $display("FAIL rand resp s=%0d got %h/%h/%b exp %h/%h/%b", s, resp_addr, resp_inst, resp_err, q[0].addr, q[0].inst, q[0].err);
        end
      end
      @(posedge clk); @(negedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_streaming();
    for (int s = 0; s < 20; s++) begin
      s_req_val = s < 16;
      s_req_addr = s * 4;
      if (s < 16) begin
        n_chk++;
        if (s_req_rdy !== 1'b1) begin n_fail++; $display("FAIL stream req_rdy s=%0d got %b exp 1", s, s_req_rdy); end
      end
      n_chk++;
      if (s_resp_val !== (s >= 2 && s < 18)) begin n_fail++; $display("FAIL stream resp_val s=%0d got %b exp %b", s, s_resp_val, s >= 2 && s < 18); end
      if (s >= 2 && s < 18) begin
        n_chk++;
        if ({s_resp_addr, s_resp_inst, s_resp_err} !== {32'((s - 2) * 4), smem[s-2], 1'b0}) begin
          n_fail++; $display("FAIL stream resp s=%0d got %h/%h/%b exp %h/%h/0", s, s_resp_addr, s_resp_inst, s_resp_err, (s - 2) * 4, smem[s-2]);
        end
      end
      @(posedge clk); @(negedge clk); #1;
    end
    s_req_val = 1'b0;
  endtask

  initial begin
    test_reset();
    preload();
    test_single();
    test_backpressure();
    test_errors();
    test_collision();
    test_reset_midflight();
    test_random();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
